// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and its consumers.
//   - STG_* : bit index of each pipeline register in pipe_stall/pipe_flush
//   - STALL_*/FLUSH_* : per-cause hold/bubble patterns
//   - state_e : sequencer FSM encoding
package pipe_ctrl_pkg;

  localparam int STG_PC = 0;
  localparam int STG_IF = 1;
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;
  localparam int STG_WB = 4;

  // Data RAM wait: freeze PC..EX/MEM, bubble into MEM/WB.
  localparam logic [4:0] STALL_DRAM = 5'b01111;
  localparam logic [4:0] FLUSH_DRAM = 5'b10000;
  // Multi-cycle mul/div: freeze PC..ID/EX, bubble into EX/MEM.
  localparam logic [4:0] STALL_MD   = 5'b00111;
  localparam logic [4:0] FLUSH_MD   = 5'b01000;
  // Load-use: freeze PC and IF/ID, bubble into ID/EX.
  localparam logic [4:0] STALL_LU   = 5'b00011;
  localparam logic [4:0] FLUSH_LU   = 5'b00100;
  // Redirect: squash the two wrong-path instructions in IF/ID and ID/EX.
  localparam logic [4:0] FLUSH_BJ   = 5'b00110;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for the pipeline sequencer (built only with
// PIPE_CTRL_PERF_EN). All counters clear on reset and wrap.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_stall_any     any pipe_stall bit set this cycle
//   i_bj_flag       redirect strobe issued this cycle
//   i_md_err        mul/div timeout pulse
//   o_stall_cyc     stalled-cycle count
//   o_flush_cnt     redirect count
//   o_md_err_cnt    timeout count
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall_any,
  input  logic        i_bj_flag,
  input  logic        i_md_err,
  output logic [31:0] o_stall_cyc,
  output logic [31:0] o_flush_cnt,
  output logic [15:0] o_md_err_cnt
);

  logic [31:0] r_stall_cyc;
  logic [31:0] r_flush_cnt;
  logic [15:0] r_md_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cyc  <= '0;
      r_flush_cnt  <= '0;
      r_md_err_cnt <= '0;
    end else begin
      if (i_stall_any) r_stall_cyc  <= r_stall_cyc + 32'd1;
      if (i_bj_flag)   r_flush_cnt  <= r_flush_cnt + 32'd1;
      if (i_md_err)    r_md_err_cnt <= r_md_err_cnt + 16'd1;
    end
  end

  assign o_stall_cyc  = r_stall_cyc;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_md_err_cnt = r_md_err_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core. Turns load-use, multi-cycle
// mul/div, data-RAM wait and EX redirects into per-register hold/bubble
// controls, and forwards the redirect to the fetch stage.
// Bit index of pipe_stall/pipe_flush: 0=PC 1=IF/ID 2=ID/EX 3=EX/MEM 4=MEM/WB.
// Optional build macro: PIPE_CTRL_PERF_EN adds perf_* counter outputs.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (outputs 0 while low)
//   id_ld_use       load in EX feeds a source reg of the ID instruction
//   ex_md_start     mul/div issued from EX
//   ex_md_done      mul/div result valid
//   mem_dram_wait   data RAM not ready
//   ex_bj_flag      branch taken / jump resolved in EX
//   ex_bj_addr      redirect target
//   pipe_stall      1 = hold register i
//   pipe_flush      1 = load bubble into register i
//   bj_flag/bj_addr redirect to if_stage
//   md_err          1-cycle pulse on mul/div timeout
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64   // legal 2..1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_ld_use,
  input  logic        ex_md_start,
  input  logic        ex_md_done,
  input  logic        mem_dram_wait,
  input  logic        ex_bj_flag,
  input  logic [31:0] ex_bj_addr,
  output logic [4:0]  pipe_stall,
  output logic [4:0]  pipe_flush,
  output logic        bj_flag,
  output logic [31:0] bj_addr,
  output logic        md_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [15:0] perf_md_err_cnt
`endif
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] MD_LAST = CW'(MD_TIMEOUT - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_md_cnt;
  logic [CW-1:0]   w_md_cnt_nxt;
  logic            r_lu_q;
  logic            w_lu_nxt;
  logic            w_md_hold;
  logic            w_md_timeout;
  logic [4:0]      w_stall;
  logic [4:0]      w_flush;
  logic            w_bj;
  logic [31:0]     w_bj_addr;

  // NOTE: only the control state is reset; it is all flops, no memory, so a
  // plain synchronous clear is cheap and every path starts from a known value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
      r_lu_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of
      // statement order.
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      r_lu_q   <= w_lu_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_lu_nxt     = 1'b0;
    w_md_hold    = 1'b0;
    w_md_timeout = 1'b0;
    w_stall      = '0;
    w_flush      = '0;
    w_bj         = 1'b0;
    w_bj_addr    = '0;

    case (r_state)
      ST_RUN: begin
        // start&done together is a single-cycle op: no stall, stay in RUN.
        // A stray done in RUN is ignored.
        if (ex_md_start && !ex_md_done) begin
          w_state_nxt  = ST_MD_BUSY;
          w_md_cnt_nxt = '0;
          w_md_hold    = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        if (ex_md_done) begin
          w_state_nxt  = ST_RUN;
          w_md_cnt_nxt = '0;
        end else if (r_md_cnt == MD_LAST) begin
          // Forced release: the stall drops in the same cycle as the error.
          w_state_nxt  = ST_RUN;
          w_md_cnt_nxt = '0;
          w_md_timeout = 1'b1;
        end else begin
          w_md_cnt_nxt = r_md_cnt + CW'(1);
          w_md_hold    = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase

    // Priority mux, first match wins. A branch blocked by any higher cause
    // stays parked in ID/EX and redirects on the first unblocked cycle.
    if (mem_dram_wait) begin
      w_stall = STALL_DRAM;
      w_flush = FLUSH_DRAM;
    end else if (w_md_hold) begin
      w_stall = STALL_MD;
      w_flush = FLUSH_MD;
    end else if (id_ld_use && !r_lu_q) begin
      // lu_q limits the load-use bubble to one cycle even if id_ld_use stays
      // high while the load advances.
      w_stall  = STALL_LU;
      w_flush  = FLUSH_LU;
      w_lu_nxt = 1'b1;
    end else if (ex_bj_flag) begin
      w_flush   = FLUSH_BJ;
      w_bj      = 1'b1;
      w_bj_addr = ex_bj_addr;
    end
  end

  assign pipe_stall = rst_n ? w_stall   : '0;
  assign pipe_flush = rst_n ? w_flush   : '0;
  assign bj_flag    = rst_n & w_bj;
  assign bj_addr    = rst_n ? w_bj_addr : '0;
  assign md_err     = rst_n & w_md_timeout;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_stall_any  (|pipe_stall),
    .i_bj_flag    (bj_flag),
    .i_md_err     (md_err),
    .o_stall_cyc  (perf_stall_cyc),
    .o_flush_cnt  (perf_flush_cnt),
    .o_md_err_cnt (perf_md_err_cnt)
  );
`endif

endmodule
